fifo18_to_gmii_tx: RTL
======================

Name: fifo18_to_gmii_tx

Overview:
- PHY-side Ethernet transmitter, the egress counterpart of the gmii2fifo18 receive path.
- Drains frames from an 18-bit TX FIFO, which the host/DMA side fills through an afifo18 in the TX clock domain.
- Emits GMII TX with preamble/SFD, pads short frames to 60 bytes, appends the CRC-32 FCS and enforces the inter-frame gap.
- Sits inside the ENABLE_TRANSMITTER path, one instance per PHY.

Parameters:
- Gap, 4'hC: idle bytes (tx_en low) forced after every frame, including aborted ones; legal range 1..15.

Ports:
- sys_clk  in  1  125 MHz GMII TX clock (phyN_125M_clk); also the FIFO read clock.
- sys_rst  in  1  synchronous reset, active high.
- dout  in  18  FIFO word: [15:8] first byte, [7:0] second byte, [16] odd (EOF word carries only [15:8]), [17] EOF (last word of frame).
- empty  in  1  FIFO empty.
- rd_en  out  1  FIFO read strobe; Q valid the cycle after rd_en.
- tx_enable  in  1  1 = may start new frames; 0 = finish current frame then stay idle.
- gmii_tx_en  out  1  GMII TX enable (registered).
- gmii_txd  out  8  GMII TX data (registered).
- tx_busy  out  1  high in any state other than IDLE.
- frame_cnt  out  16  frames completed with FCS; wraps.
- underrun_cnt  out  8  aborted frames; saturates at 8'hFF.

Behaviour:
- Reset: rd_en=0, gmii_tx_en=0, gmii_txd=8'h00, tx_busy=0, frame_cnt=0, underrun_cnt=0, CRC=32'hFFFFFFFF, state=IDLE. Reset mid-frame drops tx_en on the next edge; no FCS is sent and the FIFO is not flushed.
- States: IDLE, PRE, SFD, DHI, DLO, PAD, FCS, FLUSH, GAP.
- IDLE: when tx_enable & ~empty at edge N, go to PRE. gmii_tx_en=1, txd=8'h55 from N+1.
- PRE: 7 cycles of 8'h55. rd_en pulses for one cycle in the 7th PRE cycle. Then SFD: 8'hD5, and the first word is latched.
- DHI: txd = word[15:8].
  - If EOF & odd, the frame data ends here. Go to PAD if byte_cnt < 60, else FCS.
  - Otherwise go to DLO.
- DLO: txd = word[7:0].
  - If EOF: go to PAD if byte_cnt < 60, else FCS.
  - Else if ~empty: rd_en=1 this cycle, latch the word, go to DHI.
  - Else (underrun): go to FLUSH. tx_en drops on the next cycle; the truncated frame has no FCS; underrun_cnt++.
- byte_cnt: 11 bits, counts payload+pad bytes sent after SFD.
- PAD: send 8'h00 until byte_cnt == 60, then FCS.
- FCS: 4 bytes of ~CRC, bit-reversed per IEEE 802.3, least significant byte first.
  - CRC-32 (poly 04C11DB7, reflected) accumulates over payload and pad bytes only.
  - CRC resets to 32'hFFFFFFFF at SFD.
  - After the last FCS byte: frame_cnt++, go to GAP.
- FLUSH: tx_en=0. Pulse rd_en whenever ~empty, one read per 2 cycles to honour Q latency, discarding words until a word with EOF is read. Then go to GAP.
- GAP: tx_en=0, txd=0 for Gap cycles, then IDLE.
- tx_en duration: 8 + max(n,60) + 4 cycles for n payload bytes (n ≥ 1).
- rd_en never asserts while empty=1. rd_en never asserts in IDLE, SFD, PAD, FCS or GAP.
- tx_enable deasserted mid-frame has no effect until IDLE.
- Payload length is not limited; oversize frames are sent as supplied.

Test Plan:
- 60-byte frame (30 words, last EOF, odd=0), FIFO pre-filled → tx_en high exactly 72 cycles: 7×55, D5, 60 data bytes, 4 FCS bytes matching the bench CRC model; frame_cnt=1; 30 rd_en pulses.
- 15-byte frame (8 words, EOF word odd=1) → 15 data bytes, 45×00 pad, FCS over the 60 bytes; tx_en 72 cycles.
- Two 64-byte frames back to back, FIFO never empty → exactly Gap=12 low cycles between frames; frame_cnt=2; second frame's FCS correct (CRC re-seeded).
- Underrun: 10 words of a 40-word frame available, remainder pushed 50 cycles later → tx_en drops after 20 data bytes with no D5 repeat and no FCS; underrun_cnt=1; remaining 30 words flushed through EOF; next frame transmits correctly after Gap.
- Reset asserted during DHI of a frame → next cycle tx_en=0, txd=00, tx_busy=0, both counters 0; with FIFO non-empty and tx_enable=1, PRE starts 1 cycle after reset release.
- tx_enable=0 with FIFO non-empty → rd_en and tx_en stay 0. tx_enable raised → 8'h55 appears 1 cycle later.

Source files
------------

// File: rtl/fifo18_to_gmii_tx.sv
// fifo18_to_gmii_tx: drains 18-bit frame words from the TX FIFO and emits GMII
// with preamble/SFD, zero padding to 60 bytes, CRC-32 FCS and inter-frame gap.
// The GMII output registers carry the byte chosen by the state of the previous
// cycle, so the byte on gmii_txd always trails the controlling state by one clock.
module fifo18_to_gmii_tx #(
   parameter logic [3:0] Gap = 4'hC
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [17:0] dout,
   input  logic        empty,
   output logic        rd_en,
   input  logic        tx_enable,
   output logic        gmii_tx_en,
   output logic [7:0]  gmii_txd,
   output logic        tx_busy,
   output logic [15:0] frame_cnt,
   output logic [7:0]  underrun_cnt
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_SFD, S_DHI, S_DLO, S_PAD, S_FCS, S_FLUSH, S_GAP
   } state_t;

   localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
   localparam logic [10:0] MinLen  = 11'd60;

   // Reflected CRC-32 (0x04C11DB7 reversed = 0xEDB88320), data taken LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
         else                c = c >> 1;
      end
      return c;
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;            // PRE / FCS / GAP cycle counter
   logic [10:0] byte_cnt_q, byte_cnt_d;  // payload + pad bytes since SFD
   logic [31:0] crc_q, crc_d;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  txd_q, txd_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  underrun_cnt_q, underrun_cnt_d;
   logic [17:0] word_q;
   logic        rd_q;
   logic [17:0] cur_word;
   logic [10:0] byte_inc;

   // FIFO Q is valid only the cycle after rd_en; afterwards the held copy is used.
   assign cur_word = rd_q ? dout : word_q;
   // Byte count including the byte being sent now; saturates for oversize frames.
   assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;

   // Next-state, FIFO read strobe and next GMII byte.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d        = state_q;
      cnt_d          = cnt_q;
      byte_cnt_d     = byte_cnt_q;
      crc_d          = crc_q;
      frame_cnt_d    = frame_cnt_q;
      underrun_cnt_d = underrun_cnt_q;
      rd_en          = 1'b0;
      tx_en_d        = 1'b0;
      txd_d          = 8'h00;
      case (state_q)
         S_IDLE: begin
            if (tx_enable && !empty) begin
               state_d = S_PRE;
               cnt_d   = 4'd0;
            end
         end
         S_PRE: begin
            tx_en_d = 1'b1;
            txd_d   = 8'h55;
            if (cnt_q == 4'd6) begin
               rd_en   = !empty;
               state_d = S_SFD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_SFD: begin
            tx_en_d    = 1'b1;
            txd_d      = 8'hD5;
            crc_d      = CrcInit;
            byte_cnt_d = 11'd0;
            state_d    = S_DHI;
         end
         S_DHI: begin
            tx_en_d    = 1'b1;
            txd_d      = cur_word[15:8];
            crc_d      = crc32_byte(crc_q, cur_word[15:8]);
            byte_cnt_d = byte_inc;
            if (cur_word[17] && cur_word[16]) begin
               if (byte_inc < MinLen) state_d = S_PAD;
               else begin
                  state_d = S_FCS;
                  cnt_d   = 4'd0;
               end
            end else begin
               state_d = S_DLO;
            end
         end
         S_DLO: begin
            tx_en_d    = 1'b1;
            txd_d      = cur_word[7:0];
            crc_d      = crc32_byte(crc_q, cur_word[7:0]);
            byte_cnt_d = byte_inc;
            if (cur_word[17]) begin
               if (byte_inc < MinLen) state_d = S_PAD;
               else begin
                  state_d = S_FCS;
                  cnt_d   = 4'd0;
               end
            end else if (!empty) begin
               rd_en   = 1'b1;
               state_d = S_DHI;
            end else begin
               state_d = S_FLUSH;
               if (underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
            end
         end
         S_PAD: begin
            tx_en_d    = 1'b1;
            crc_d      = crc32_byte(crc_q, 8'h00);
            byte_cnt_d = byte_inc;
            if (byte_inc == MinLen) begin
               state_d = S_FCS;
               cnt_d   = 4'd0;
            end
         end
         S_FCS: begin
            tx_en_d = 1'b1;
            case (cnt_q[1:0])
               2'd0:    txd_d = ~crc_q[7:0];
               2'd1:    txd_d = ~crc_q[15:8];
               2'd2:    txd_d = ~crc_q[23:16];
               default: txd_d = ~crc_q[31:24];
            endcase
            if (cnt_q == 4'd3) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = S_GAP;
               cnt_d       = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_FLUSH: begin
            // A word arrives every other cycle at most; stop once the EOF word is seen.
            if (rd_q) begin
               if (dout[17]) begin
                  state_d = S_GAP;
                  cnt_d   = 4'd0;
               end
            end else if (!empty) begin
               rd_en = 1'b1;
            end
         end
         S_GAP: begin
            // Start the next preamble straight from the last gap cycle so the line
            // is idle for exactly Gap cycles between back-to-back frames.
            if (cnt_q == Gap - 4'd1) begin
               cnt_d = 4'd0;
               if (tx_enable && !empty) state_d = S_PRE;
               else                     state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and output registers, all cleared by the synchronous reset.
   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (sys_rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= 4'd0;
         byte_cnt_q     <= 11'd0;
         crc_q          <= CrcInit;
         tx_en_q        <= 1'b0;
         txd_q          <= 8'h00;
         frame_cnt_q    <= 16'd0;
         underrun_cnt_q <= 8'd0;
         word_q         <= 18'd0;
         rd_q           <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         byte_cnt_q     <= byte_cnt_d;
         crc_q          <= crc_d;
         tx_en_q        <= tx_en_d;
         txd_q          <= txd_d;
         frame_cnt_q    <= frame_cnt_d;
         underrun_cnt_q <= underrun_cnt_d;
         word_q         <= cur_word;
         rd_q           <= rd_en;
      end
   end

   assign gmii_tx_en   = tx_en_q;
   assign gmii_txd     = txd_q;
   assign tx_busy      = (state_q != S_IDLE);
   assign frame_cnt    = frame_cnt_q;
   assign underrun_cnt = underrun_cnt_q;

endmodule
